rv32_multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle RV32I core, the successor to the single-cycle combinational decoder.
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK over several cycles, and stalls on a shared memory handshake.
- Drives the datapath muxes, PC/IR enables and the 4-bit ALU op. The ALU-op encoding is unchanged so the existing ALU is reused.
- Adds illegal-opcode and memory-timeout traps plus a retired-instruction counter.

---
 rtl/rv32_ctrl_pkg.sv | 74 +++++++
 rtl/rv32_alu_decode.sv | 49 ++++
 rtl/rv32_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared encodings for the RV32I multi-cycle control path and its ALU decoder.
// Defining RV32M_MULDIV_EN adds the MULDIV state and the M-extension func7 code.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef RV32M_MULDIV_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_TRAP
`ifdef RV32M_MULDIV_EN
        , ST_MULDIV
`endif
    } state_t;

    // alt selects SUB over ADD and SRA over SRL; callers decide when func7[5] is meaningful.
    function automatic logic [3:0] alu_op_from_func3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// rv32_alu_decode: combinational opcode/func3/func7 to ALU op and legality, shared with the single-cycle core.
// Under RV32M_MULDIV_EN, R-type func7 = 0000001 is legal and flagged as a mul/div op.
module rv32_alu_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op,
    output logic       legal
`ifdef RV32M_MULDIV_EN
    ,
    output logic       muldiv
`endif
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op = ALU_ADD;
        legal  = 1'b0;
`ifdef RV32M_MULDIV_EN
        muldiv = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (func7 == F7_BASE ||
                    (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101))) begin
                    legal  = 1'b1;
                    alu_op = alu_op_from_func3(func3, func7[5]);
                end
`ifdef RV32M_MULDIV_EN
                else if (func7 == F7_MULDIV) begin
                    legal  = 1'b1;
                    muldiv = 1'b1;
                    alu_op = {1'b1, func3};
                end
`endif
            end
            OP_IMM: begin
                // In I-arith the func7 field is immediate bits except for the shift-right pair.
                legal  = 1'b1;
                alu_op = alu_op_from_func3(func3, (func3 == 3'b101) && func7[5]);
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: multi-cycle RV32I control FSM with illegal-opcode/memory-timeout traps and instret.
// Defining RV32M_MULDIV_EN adds the MULDIV state and the muldiv_start port.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef RV32M_MULDIV_EN
    ,
    output logic             muldiv_start
`endif
);

    localparam int WAIT_MAX = (MEM_TIMEOUT > MUL_LATENCY) ? MEM_TIMEOUT : MUL_LATENCY;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t             state, next_state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instret_q;
    logic               trap_q;
    logic [1:0]         cause_q, next_cause;
    logic [3:0]         dec_alu_op;
    logic               dec_legal;
    logic               timed_out;
    logic               is_load, is_store;
`ifdef RV32M_MULDIV_EN
    logic               dec_muldiv;
`endif

    rv32_alu_decode u_alu_decode (
        .opcode (opcode),
        .func3  (func3),
        .func7  (func7),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
`ifdef RV32M_MULDIV_EN
        ,
        .muldiv (dec_muldiv)
`endif
    );

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign timed_out = (MEM_TIMEOUT != 0) && (int'(wait_cnt) + 1 >= MEM_TIMEOUT);

    always_comb begin
        next_state = state;
        next_cause = CAUSE_NONE;
        case (state)
            ST_FETCH: begin
                // A response arriving on the limit cycle still completes the fetch.
                if (mem_ready) begin
                    next_state = ST_DECODE;
                end else if (timed_out) begin
                    next_state = ST_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    next_state = ST_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
`ifdef RV32M_MULDIV_EN
                else if (dec_muldiv) next_state = ST_MULDIV;
`endif
                else next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_load || is_store)      next_state = ST_MEMORY;
                else if (opcode == OP_BRANCH) next_state = ST_FETCH;
                else                          next_state = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    next_state = is_load ? ST_WRITEBACK : ST_FETCH;
                end else if (timed_out) begin
                    next_state = ST_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
`ifdef RV32M_MULDIV_EN
            ST_MULDIV: if (int'(wait_cnt) + 1 >= MUL_LATENCY) next_state = ST_WRITEBACK;
`endif
            ST_WRITEBACK: next_state = ST_FETCH;
            ST_TRAP:      next_state = ST_TRAP;
            default:      next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (rst) begin
            state     <= ST_FETCH;
            wait_cnt  <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state <= next_state;
            if (next_state != state)  wait_cnt <= '0;
            else if (state != ST_TRAP) wait_cnt <= wait_cnt + 1'b1;
            if (instr_retired) instret_q <= instret_q + CNT_W'(1);
            if (next_state == ST_TRAP && state != ST_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= next_cause;
            end
        end
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = PC_PLUS4;
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_retired = 1'b0;
`ifdef RV32M_MULDIV_EN
        muldiv_start  = 1'b0;
`endif
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_PC;
                    alu_src_b = 1'b1;
                end
                ST_EXECUTE: begin
                    alu_op = dec_alu_op;
                    case (opcode)
                        OP_IMM, OP_LOAD, OP_STORE: alu_src_b = 1'b1;
                        OP_BRANCH: begin
                            pc_write      = branch_taken;
                            pc_sel        = PC_TARGET;
                            instr_retired = 1'b1;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_sel   = PC_TARGET;
                        end
                        OP_JALR: begin
                            alu_src_b = 1'b1;
                            pc_write  = 1'b1;
                            pc_sel    = PC_JALR;
                        end
                        OP_LUI: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = 1'b1;
                        end
                        OP_AUIPC: begin
                            alu_src_a = SRC_A_PC;
                            alu_src_b = 1'b1;
                        end
                        default: alu_src_b = 1'b0;
                    endcase
                end
                ST_MEMORY: begin
                    addr_sel      = 1'b1;
                    mem_read      = is_load;
                    mem_write     = is_store;
                    instr_retired = is_store && mem_ready;
                end
`ifdef RV32M_MULDIV_EN
                ST_MULDIV: begin
                    alu_op       = dec_alu_op;
                    muldiv_start = (wait_cnt == '0);
                end
`endif
                ST_WRITEBACK: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    if (is_load)                                   wb_sel = WB_MEM;
                    else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel = WB_PC4;
                    else                                           wb_sel = WB_ALU;
                end
                default: instr_retired = 1'b0;
            endcase
        end
    end

    assign instret    = rst ? '0 : instret_q;
    assign trap       = rst ? 1'b0 : trap_q;
    assign trap_cause = rst ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: directed per-cycle scoreboard for the multi-cycle RV32I control FSM.
// Build with +define+RV32M_MULDIV_EN to exercise the MULDIV path instead of the MUL trap.
module tb_rv32_multicycle_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_retired;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_t;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [CNT_W-1:0] instret;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = '0;
    logic [2:0]       func3 = '0;
    logic [6:0]       func7 = '0;
    logic             mem_ready = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_read, mem_write, addr_sel, ir_write, pc_write;
    logic [1:0]       pc_sel, alu_src_a, wb_sel, trap_cause;
    logic             alu_src_b, reg_write, instr_retired, trap;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] instret;
`ifdef RV32M_MULDIV_EN
    logic             muldiv_start;
`endif

    ctrl_t            obs;
    sb_t              sb_q[$];
    logic [CNT_W-1:0] model_instret = '0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    rv32_multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (CNT_W),
        .MUL_LATENCY (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .func3         (func3),
        .func7         (func7),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr_sel      (addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .instr_retired (instr_retired),
        .instret       (instret),
        .trap          (trap),
        .trap_cause    (trap_cause)
`ifdef RV32M_MULDIV_EN
        ,
        .muldiv_start  (muldiv_start)
`endif
    );

    assign obs = {mem_read, mem_write, addr_sel, ir_write, pc_write, pc_sel, alu_src_a,
                  alu_src_b, alu_op, reg_write, wb_sel, instr_retired, trap, trap_cause};

    function automatic ctrl_t v_fetch(input logic ready);
        ctrl_t c;
        c = '0;
        c.mem_read = 1'b1;
        c.ir_write = ready;
        c.pc_write = ready;
        return c;
    endfunction

    function automatic ctrl_t v_decode();
        ctrl_t c;
        c = '0;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_exec(input logic [3:0] op, input logic [1:0] sa, input logic sb,
                                     input logic pcw, input logic [1:0] pcs, input logic ret);
        ctrl_t c;
        c = '0;
        c.alu_op        = op;
        c.alu_src_a     = sa;
        c.alu_src_b     = sb;
        c.pc_write      = pcw;
        c.pc_sel        = pcs;
        c.instr_retired = ret;
        return c;
    endfunction

    function automatic ctrl_t v_mem(input logic rd, input logic wr, input logic ret);
        ctrl_t c;
        c = '0;
        c.addr_sel      = 1'b1;
        c.mem_read      = rd;
        c.mem_write     = wr;
        c.instr_retired = ret;
        return c;
    endfunction

    function automatic ctrl_t v_wb(input logic [1:0] sel);
        ctrl_t c;
        c = '0;
        c.reg_write     = 1'b1;
        c.wb_sel        = sel;
        c.instr_retired = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t v_trap(input logic [1:0] cause);
        ctrl_t c;
        c = '0;
        c.trap       = 1'b1;
        c.trap_cause = cause;
        return c;
    endfunction

    // One clock: drive at the falling edge, push the expectation, pop and compare 2 ns later.
    task automatic cyc(input logic r, input logic mr, input logic bt, input ctrl_t exp, input string tag);
        sb_t e;
        @(negedge clk);
        rst          = r;
        mem_ready    = mr;
        branch_taken = bt;
        e.ctrl    = exp;
        e.instret = r ? '0 : model_instret;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.ctrl) else begin
            errors++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, e.ctrl);
        end
        checks++;
        assert (instret === e.instret) else begin
            errors++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, e.instret);
        end
        if (r)                      model_instret = '0;
        else if (exp.instr_retired) model_instret = model_instret + 1'b1;
    endtask

    // Fetch completes this cycle; the IR fields become valid for the following cycles.
    task automatic fetch_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input string tag);
        cyc(1'b0, 1'b1, 1'b0, v_fetch(1'b1), {tag, "_fetch"});
        opcode = op;
        func3  = f3;
        func7  = f7;
    endtask

    task automatic run_simple(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input ctrl_t exe, input logic [1:0] wsel, input string tag);
        fetch_instr(op, f3, f7, tag);
        cyc(1'b0, 1'b1, 1'b0, v_decode(), {tag, "_decode"});
        cyc(1'b0, 1'b1, 1'b0, exe, {tag, "_execute"});
        cyc(1'b0, 1'b1, 1'b0, v_wb(wsel), {tag, "_writeback"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset holds every output low even with mem_ready and branch_taken high.
        cyc(1'b1, 1'b1, 1'b1, '0, "reset0");
        cyc(1'b1, 1'b1, 1'b1, '0, "reset1");

        run_simple(7'b0110011, 3'b000, 7'b0000000, v_exec(4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), 2'b00, "add");
        run_simple(7'b0110011, 3'b000, 7'b0100000, v_exec(4'b0001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), 2'b00, "sub");
        run_simple(7'b0110011, 3'b011, 7'b0000000, v_exec(4'b1001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), 2'b00, "sltu");
        run_simple(7'b0010011, 3'b101, 7'b0100000, v_exec(4'b0111, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0), 2'b00, "srai");
        run_simple(7'b0010011, 3'b000, 7'b0100000, v_exec(4'b0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0), 2'b00, "addi_hi");
        run_simple(7'b0110111, 3'b101, 7'b0100000, v_exec(4'b0000, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0), 2'b00, "lui");
        run_simple(7'b0010111, 3'b000, 7'b0000000, v_exec(4'b0000, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0), 2'b00, "auipc");
        run_simple(7'b1101111, 3'b000, 7'b0000000, v_exec(4'b0000, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0), 2'b10, "jal");
        run_simple(7'b1100111, 3'b000, 7'b0000000, v_exec(4'b0000, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0), 2'b10, "jalr");

        // LW with three stalled MEMORY cycles: 8 cycles total.
        fetch_instr(7'b0000011, 3'b010, 7'b0000000, "lw");
        cyc(1'b0, 1'b1, 1'b0, v_decode(), "lw_decode");
        cyc(1'b0, 1'b1, 1'b0, v_exec(4'b0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0), "lw_execute");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, v_mem(1'b1, 1'b0, 1'b0), "lw_mem_stall");
        cyc(1'b0, 1'b1, 1'b0, v_mem(1'b1, 1'b0, 1'b0), "lw_mem_done");
        cyc(1'b0, 1'b1, 1'b0, v_wb(2'b01), "lw_writeback");

        // SW retires from MEMORY and never writes the register file.
        fetch_instr(7'b0100011, 3'b010, 7'b0000000, "sw");
        cyc(1'b0, 1'b1, 1'b0, v_decode(), "sw_decode");
        cyc(1'b0, 1'b1, 1'b0, v_exec(4'b0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0), "sw_execute");
        cyc(1'b0, 1'b0, 1'b0, v_mem(1'b0, 1'b1, 1'b0), "sw_mem_stall");
        cyc(1'b0, 1'b1, 1'b0, v_mem(1'b0, 1'b1, 1'b1), "sw_mem_done");

        // BEQ taken then not taken: 3 cycles each, both retire in EXECUTE.
        fetch_instr(7'b1100011, 3'b000, 7'b0000000, "beq_t");
        cyc(1'b0, 1'b1, 1'b1, v_decode(), "beq_t_decode");
        cyc(1'b0, 1'b1, 1'b1, v_exec(4'b0000, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1), "beq_t_execute");
        fetch_instr(7'b1100011, 3'b000, 7'b0000000, "beq_n");
        cyc(1'b0, 1'b1, 1'b0, v_decode(), "beq_n_decode");
        cyc(1'b0, 1'b1, 1'b0, v_exec(4'b0000, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1), "beq_n_execute");

        // Reset in the middle of a stalled load drops the request with no retire.
        fetch_instr(7'b0000011, 3'b010, 7'b0000000, "lw_rst");
        cyc(1'b0, 1'b1, 1'b0, v_decode(), "lw_rst_decode");
        cyc(1'b0, 1'b1, 1'b0, v_exec(4'b0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0), "lw_rst_execute");
        cyc(1'b0, 1'b0, 1'b0, v_mem(1'b1, 1'b0, 1'b0), "lw_rst_mem");
        cyc(1'b1, 1'b1, 1'b0, '0, "lw_rst_reset");

        // Fetch timeout: 16 waiting cycles, then TRAP with cause 10.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, v_fetch(1'b0), "tmo_fetch_wait");
        for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, 1'b1, v_trap(2'b10), "tmo_trap");
        cyc(1'b1, 1'b0, 1'b0, '0, "tmo_reset");

        // Ready on exactly the 16th fetch cycle wins over the timeout.
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, v_fetch(1'b0), "edge_fetch_wait");
        run_simple(7'b0110011, 3'b000, 7'b0000000, v_exec(4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), 2'b00, "edge_add");

        // Illegal opcode traps after DECODE and stays put until reset.
        fetch_instr(7'b1111111, 3'b000, 7'b0000000, "ill");
        cyc(1'b0, 1'b1, 1'b1, v_decode(), "ill_decode");
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, v_trap(2'b01), "ill_trap");
        cyc(1'b1, 1'b1, 1'b1, '0, "ill_reset");
        run_simple(7'b0110011, 3'b111, 7'b0000000, v_exec(4'b0010, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), 2'b00, "and_after_trap");

        fetch_instr(7'b0110011, 3'b000, 7'b0000001, "mul");
        cyc(1'b0, 1'b1, 1'b0, v_decode(), "mul_decode");
`ifdef RV32M_MULDIV_EN
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, v_exec(4'b1000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0), "mul_busy");
            checks++;
            assert (muldiv_start === (k == 0)) else begin
                errors++;
                $error("FAIL mul_start observed=%b expected=%b", muldiv_start, (k == 0));
            end
        end
        cyc(1'b0, 1'b1, 1'b0, v_wb(2'b00), "mul_writeback");
`else
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, v_trap(2'b01), "mul_trap");
        cyc(1'b1, 1'b1, 1'b0, '0, "mul_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
